tcp_payload_packer: RTL



---
 rtl/tcp_payload_packer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tcp_payload_packer.sv
// Packs a byte stream into 32-bit big-endian words for two ping-pong TCP write
// memories, tracking each segment's byte length and one's-complement payload sum.
module tcp_payload_packer #(
  parameter int MAX_LEN   = 1024,
  parameter int IDLE_TOUT = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_dat_i,
  input  logic        s_val_i,
  input  logic        s_last_i,
  output logic        s_rdy_o,
  input  logic [1:0]  wr_lock_i,
  output logic [31:0] wdat_o,
  output logic        wr_o,
  output logic [1:0]  wr_sel_o,
  output logic        wr_op_stop_o,
  output logic [15:0] wdat_chksum_o,
  output logic [15:0] wdat_len_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, FILL, LAST_WR, STOP, WAIT_LOCK} state_t;

  localparam int              TW        = (IDLE_TOUT > 1) ? $clog2(IDLE_TOUT) : 1;
  localparam logic [TW-1:0]   TOUT_LAST = TW'((IDLE_TOUT > 0) ? IDLE_TOUT - 1 : 0);
  localparam logic [11:0]     LEN_LAST  = 12'(MAX_LEN - 1);

  state_t        state;
  logic          ptr;
  logic [11:0]   byte_cnt;
  logic [15:0]   acc;
  logic [31:0]   pack;
  logic [7:0]    hi_byte;
  logic [TW-1:0] tout_cnt;

  logic          accept;
  logic          close_by_byte;
  logic          idle_tick;
  logic          tout_hit;
  logic [1:0]    lane;
  logic [31:0]   pack_next;
  logic [15:0]   acc_byte;
  logic [15:0]   acc_tout;

  // One's-complement add; a+b folded once can never carry again.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  assign lane          = byte_cnt[1:0];
  assign accept        = s_val_i & s_rdy_o;
  assign close_by_byte = accept & (s_last_i | (byte_cnt == LEN_LAST));
  assign idle_tick     = (IDLE_TOUT != 0) && (state == FILL) && (byte_cnt != 12'd0) && !accept;
  assign tout_hit      = idle_tick && (tout_cnt == TOUT_LAST);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    pack_next = pack;
    case (lane)
      2'd0:    pack_next[31:24] = s_dat_i;
      2'd1:    pack_next[23:16] = s_dat_i;
      2'd2:    pack_next[15:8]  = s_dat_i;
      default: pack_next[7:0]   = s_dat_i;
    endcase
  end

  // Odd byte completes a pair; an even-position byte that closes the segment is padded with 00.
  assign acc_byte = byte_cnt[0]  ? ones_add(acc, {hi_byte, s_dat_i}) :
                    close_by_byte ? ones_add(acc, {s_dat_i, 8'h00}) : acc;
  assign acc_tout = byte_cnt[0]  ? ones_add(acc, {hi_byte, 8'h00}) : acc;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      byte_cnt      <= '0;
      acc           <= '0;
      pack          <= '0;
      hi_byte       <= '0;
      tout_cnt      <= '0;
      s_rdy_o       <= 1'b0;
      wdat_o        <= '0;
      wr_o          <= 1'b0;
      wr_sel_o      <= 2'b01;
      wr_op_stop_o  <= 1'b0;
      wdat_chksum_o <= '0;
      wdat_len_o    <= '0;
      busy_o        <= 1'b0;
    end else begin
      wr_o         <= 1'b0;
      wr_op_stop_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!wr_lock_i[ptr]) begin
            wr_sel_o <= ptr ? 2'b10 : 2'b01;
            s_rdy_o  <= 1'b1;
            busy_o   <= 1'b1;
            state    <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 12'd1;
            tout_cnt <= '0;
            acc      <= acc_byte;
            if (!byte_cnt[0]) hi_byte <= s_dat_i;
            if ((lane == 2'd3) || close_by_byte) begin
              wdat_o <= pack_next;
              wr_o   <= 1'b1;
              pack   <= '0;
            end else begin
              pack <= pack_next;
            end
            if (close_by_byte) begin
              s_rdy_o <= 1'b0;
              state   <= LAST_WR;
            end
          end else if (tout_hit) begin
            acc      <= acc_tout;
            tout_cnt <= '0;
            s_rdy_o  <= 1'b0;
            state    <= LAST_WR;
            if (lane != 2'd0) begin
              wdat_o <= pack;
              wr_o   <= 1'b1;
              pack   <= '0;
            end
          end else if (idle_tick) begin
            tout_cnt <= tout_cnt + 1'b1;
          end
        end
        LAST_WR: begin
          wr_op_stop_o  <= 1'b1;
          wdat_len_o    <= {4'd0, byte_cnt};
          wdat_chksum_o <= acc;
          state         <= STOP;
        end
        STOP: state <= WAIT_LOCK;
        WAIT_LOCK: begin
          // The reader owns this buffer once it locks it; only then move to the other one.
          if (wr_lock_i[ptr]) begin
            ptr      <= ~ptr;
            byte_cnt <= '0;
            acc      <= '0;
            hi_byte  <= '0;
            tout_cnt <= '0;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
